// File: rtl/dcpu16_alu_mc.sv
// Multi-cycle DCPU16 ALU: single-cycle basic ops plus an iterative restoring divider for DIV/MOD.
// Valid/ready request side, one-cycle result strobe; ena=0 freezes every register.
module dcpu16_alu_mc #(
  parameter int unsigned DW = 16,
  parameter int unsigned SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [3:0]    opc,
  input  logic [DW-1:0] regA,
  input  logic [DW-1:0] regB,
  output logic          res_vld,
  output logic [DW-1:0] regR,
  output logic [DW-1:0] regO,
  output logic          o_we,
  output logic          cnd
);

  // Counter must reach 2*DW, hence two bits beyond log2(DW).
  localparam int unsigned CW = SW + 2;
  localparam logic [CW-1:0] LastDiv = CW'(2 * DW);
  localparam logic [CW-1:0] LastMod = CW'(DW);

  localparam logic [3:0] OpNbi = 4'h0;
  localparam logic [3:0] OpSet = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpMul = 4'h4;
  localparam logic [3:0] OpDiv = 4'h5;
  localparam logic [3:0] OpMod = 4'h6;
  localparam logic [3:0] OpShl = 4'h7;
  localparam logic [3:0] OpShr = 4'h8;
  localparam logic [3:0] OpAnd = 4'h9;
  localparam logic [3:0] OpBor = 4'hA;
  localparam logic [3:0] OpXor = 4'hB;
  localparam logic [3:0] OpIfe = 4'hC;
  localparam logic [3:0] OpIfn = 4'hD;
  localparam logic [3:0] OpIfg = 4'hE;
  localparam logic [3:0] OpIfb = 4'hF;

  typedef enum logic [1:0] {StIdle, StExec, StDiv} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     b_q, b_d;
  logic [2*DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              res_vld_q, res_vld_d;
  logic [DW-1:0]     r_q, r_d;
  logic [DW-1:0]     o_q, o_d;
  logic              owe_q, owe_d;
  logic              cnd_q, cnd_d;

  logic [DW:0]       add_w;
  logic [DW:0]       sub_w;
  logic [2*DW-1:0]   mul_w;
  logic [2*DW-1:0]   shl_w;
  logic [2*DW-1:0]   shr_w;
  logic [DW:0]       div_sh;
  logic              div_ge;
  logic [CW-1:0]     last;

  assign add_w  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w  = {1'b0, a_q} - {1'b0, b_q};
  assign mul_w  = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
  // Oversized shift amounts fall out as zero naturally.
  assign shl_w  = {{DW{1'b0}}, a_q} << b_q;
  assign shr_w  = {a_q, {DW{1'b0}}} >> b_q;

  // Dividend bits leave the top of quo_q while quotient bits enter at the bottom.
  assign div_sh = {rem_q, quo_q[2*DW-1]};
  assign div_ge = div_sh >= {1'b0, b_q};
  assign last   = (op_q == OpDiv) ? LastDiv : LastMod;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    res_vld_d = 1'b0;
    r_d       = r_q;
    o_d       = o_q;
    owe_d     = owe_q;
    cnd_d     = cnd_q;

    unique case (state_q)
      StIdle: begin
        if (req_vld) begin
          op_d  = opc;
          a_d   = regA;
          b_d   = regB;
          quo_d = {regA, {DW{1'b0}}};
          rem_d = '0;
          cnt_d = '0;
          if ((opc == OpDiv || opc == OpMod) && regB != '0) begin
            state_d = StDiv;
          end else begin
            state_d = StExec;
          end
        end
      end

      StExec: begin
        state_d   = StIdle;
        res_vld_d = 1'b1;
        owe_d     = 1'b0;
        cnd_d     = 1'b0;
        case (op_q)
          OpSet: r_d = b_q;
          OpAdd: begin
            r_d   = add_w[DW-1:0];
            o_d   = {{(DW-1){1'b0}}, add_w[DW]};
            owe_d = 1'b1;
          end
          OpSub: begin
            r_d   = sub_w[DW-1:0];
            o_d   = {DW{sub_w[DW]}};
            owe_d = 1'b1;
          end
          OpMul: begin
            {o_d, r_d} = mul_w;
            owe_d      = 1'b1;
          end
          // Only reached with b == 0; non-zero divisors go through StDiv.
          OpDiv: begin
            r_d   = '0;
            o_d   = '0;
            owe_d = 1'b1;
          end
          OpMod: r_d = '0;
          OpShl: begin
            {o_d, r_d} = shl_w;
            owe_d      = 1'b1;
          end
          OpShr: begin
            {r_d, o_d} = shr_w;
            owe_d      = 1'b1;
          end
          OpAnd: r_d = a_q & b_q;
          OpBor: r_d = a_q | b_q;
          OpXor: r_d = a_q ^ b_q;
          OpIfe: cnd_d = (a_q == b_q);
          OpIfn: cnd_d = (a_q != b_q);
          OpIfg: cnd_d = (a_q > b_q);
          OpIfb: cnd_d = ((a_q & b_q) != '0);
          default: ;  // OpNbi: regR/regO untouched, cnd = 0
        endcase
      end

      StDiv: begin
        if (cnt_q != last) begin
          rem_d = div_ge ? (div_sh[DW-1:0] - b_q) : div_sh[DW-1:0];
          quo_d = {quo_q[2*DW-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d   = StIdle;
          res_vld_d = 1'b1;
          cnd_d     = 1'b0;
          if (op_q == OpDiv) begin
            r_d   = quo_q[2*DW-1:DW];
            o_d   = quo_q[DW-1:0];
            owe_d = 1'b1;
          end else begin
            r_d   = rem_q;
            owe_d = 1'b0;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpNbi;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      res_vld_q <= 1'b0;
      r_q       <= '0;
      o_q       <= '0;
      owe_q     <= 1'b0;
      cnd_q     <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      res_vld_q <= res_vld_d;
      r_q       <= r_d;
      o_q       <= o_d;
      owe_q     <= owe_d;
      cnd_q     <= cnd_d;
    end
  end

  assign req_rdy = (state_q == StIdle);
  assign res_vld = res_vld_q;
  assign regR    = r_q;
  assign regO    = o_q;
  assign o_we    = owe_q;
  assign cnd     = cnd_q;

endmodule

// File: tb/tb_dcpu16_alu_mc.sv
// Scoreboard bench for dcpu16_alu_mc: expectations queued at request time, checked on res_vld.
module tb_dcpu16_alu_mc;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          req_vld;
  logic          req_rdy;
  logic [3:0]    opc;
  logic [DW-1:0] regA;
  logic [DW-1:0] regB;
  logic          res_vld;
  logic [DW-1:0] regR;
  logic [DW-1:0] regO;
  logic          o_we;
  logic          cnd;

  dcpu16_alu_mc #(.DW(16), .SW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .opc     (opc),
    .regA    (regA),
    .regB    (regB),
    .res_vld (res_vld),
    .regR    (regR),
    .regO    (regO),
    .o_we    (o_we),
    .cnd     (cnd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [15:0] r;
    logic [15:0] o;
    logic        owe;
    logic        cnd;
    int          done;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_r  = '0;
  logic [15:0] model_o  = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model in plain 32-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [15:0] o,
                       output logic owe, output logic c, output int lat);
    logic [31:0] w;
    logic [16:0] s;
    r = model_r; o = model_o; owe = 1'b0; c = 1'b0; lat = 1;
    case (op)
      4'h1: r = b;
      4'h2: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; o = s[16] ? 16'h1 : 16'h0; owe = 1; end
      4'h3: begin r = a - b; o = (a < b) ? 16'hFFFF : 16'h0; owe = 1; end
      4'h4: begin w = {16'h0, a} * {16'h0, b}; r = w[15:0]; o = w[31:16]; owe = 1; end
      4'h5: begin
        owe = 1;
        if (b == 0) begin r = 0; o = 0; end
        else begin w = {a, 16'h0} / {16'h0, b}; r = w[31:16]; o = w[15:0]; lat = 33; end
      end
      4'h6: begin
        if (b == 0) r = 0;
        else begin r = a % b; lat = 17; end
      end
      4'h7: begin
        w = (b >= 32) ? 32'h0 : ({16'h0, a} << b); r = w[15:0]; o = w[31:16]; owe = 1;
      end
      4'h8: begin
        w = (b >= 32) ? 32'h0 : ({a, 16'h0} >> b); r = w[31:16]; o = w[15:0]; owe = 1;
      end
      4'h9: r = a & b;
      4'hA: r = a | b;
      4'hB: r = a ^ b;
      4'hC: c = (a == b);
      4'hD: c = (a != b);
      4'hE: c = (a > b);
      4'hF: c = ((a & b) != 0);
      default: ;
    endcase
  endtask

  task automatic send(input string tag, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input int stall_at, input int stall_len,
                      input bit track);
    int   t;
    exp_t e;
    int   lat;
    t = 0;
    @(negedge clk);
    while (!req_rdy && t < 500) begin @(negedge clk); t++; end
    if (!req_rdy) begin
      check_eq({"rdy_timeout_", tag}, 64'(req_rdy), 64'h1);
      return;
    end
    opc = op; regA = a; regB = b; req_vld = 1'b1;
    if (track) begin
      model(op, a, b, e.r, e.o, e.owe, e.cnd, lat);
      model_r = e.r; model_o = e.o;
      e.tag  = tag;
      e.done = cyc + 1 + lat + stall_len;
      sb.push_back(e);
    end
    @(negedge clk);
    req_vld = 1'b0;
    if ((op == 4'h5 || op == 4'h6) && b != 0) check_eq({"busy_rdy_", tag}, 64'(req_rdy), 64'h0);
    if (stall_len > 0) begin
      repeat (stall_at) @(negedge clk);
      ena = 1'b0;
      repeat (stall_len) @(negedge clk);
      check_eq({"stall_rdy_", tag}, 64'(req_rdy), 64'h0);
      ena = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ena && res_vld) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_res_vld", 64'h1, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq({"R_", e.tag},   64'(regR), 64'(e.r));
        check_eq({"O_", e.tag},   64'(regO), 64'(e.o));
        check_eq({"owe_", e.tag}, 64'(o_we), 64'(e.owe));
        check_eq({"cnd_", e.tag}, 64'(cnd),  64'(e.cnd));
        check_eq({"lat_", e.tag}, 64'(cyc),  64'(e.done));
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (sb.size() != 0) check_eq("drain_timeout", 64'(sb.size()), 64'h0);
    sb.delete();
  endtask

  initial begin
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    rst = 1'b1; ena = 1'b1; req_vld = 1'b0; opc = '0; regA = '0; regB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdy", 64'(req_rdy), 64'h1);
    check_eq("rst_vld", 64'(res_vld), 64'h0);
    check_eq("rst_R",   64'(regR),    64'h0);
    check_eq("rst_O",   64'(regO),    64'h0);
    check_eq("rst_owe", 64'(o_we),    64'h0);
    check_eq("rst_cnd", 64'(cnd),     64'h0);
    rst = 1'b0;

    send("add",   4'h2, 16'hFFFF, 16'h0001, 0, 0, 1);
    send("sub",   4'h3, 16'h0000, 16'h0001, 0, 0, 1);
    send("mul",   4'h4, 16'h1234, 16'h0100, 0, 0, 1);
    send("shr",   4'h8, 16'h8001, 16'h0001, 0, 0, 1);
    send("shl",   4'h7, 16'h8001, 16'h0001, 0, 0, 1);
    send("shl32", 4'h7, 16'hFFFF, 16'h0020, 0, 0, 1);
    send("div",   4'h5, 16'h0007, 16'h0002, 0, 0, 1);
    send("mod",   4'h6, 16'h0007, 16'h0002, 0, 0, 1);
    send("div0",  4'h5, 16'h1234, 16'h0000, 0, 0, 1);
    send("set",   4'h1, 16'h0000, 16'hBEEF, 0, 0, 1);
    send("ifg",   4'hE, 16'h0005, 16'h0003, 0, 0, 1);
    send("ifb",   4'hF, 16'h00F0, 16'h000F, 0, 0, 1);
    send("nbi",   4'h0, 16'h1111, 16'h2222, 0, 0, 1);
    send("mod0",  4'h6, 16'h1234, 16'h0000, 0, 0, 1);
    send("divst", 4'h5, 16'hABCD, 16'h0013, 8, 5, 1);
    send("modst", 4'h6, 16'hFFFF, 16'h0007, 3, 5, 1);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      if (rop == 4'h7 || rop == 4'h8) rb = 16'($urandom_range(0, 40));
      else if ($urandom_range(0, 4) == 0) rb = 16'h0;
      else rb = 16'($urandom);
      send($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb, 0, 0, 1);
    end
    drain();

    // Abort a division with reset; it must never produce a result.
    send("div_abort", 4'h5, 16'h1234, 16'h0007, 0, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_r = '0; model_o = '0;
    check_eq("abort_rdy", 64'(req_rdy), 64'h1);
    check_eq("abort_vld", 64'(res_vld), 64'h0);
    check_eq("abort_R",   64'(regR),    64'h0);
    check_eq("abort_O",   64'(regO),    64'h0);
    repeat (50) @(negedge clk);

    send("post_rst", 4'h2, 16'h0001, 16'h0002, 0, 0, 1);
    drain();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
